uart_tx_scheduler: RTL

Sequencing and arbitration controller for the 8-bit UART transmitter. It shares one TX instance among `NUM_REQ` byte sources using round-robin arbitration and loads the chosen byte through the TX `write_en`/`data_in` load port. It also generates the TX bit-rate strobe `tx_en` and tracks TX `busy` so that exactly one frame is in flight at a time. It sits between the system's byte producers and TX. TX `clk`/`reset` are driven from the same nets.

---
 rtl/uart_pkg.sv | 14 +
 rtl/baud_tick_gen.sv | 34 +++
 rtl/uart_tx_scheduler.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: scheduler FSM state encoding and frame constants.
package uart_pkg;

  typedef enum logic [1:0] {
    ARB       = 2'd0,
    LOAD      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } sched_state_t;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-rate strobe generator: counts CLKS_PER_BIT cycles while run is high and
// pulses tick on the last count; clear parks the counter at zero.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = run && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that shares one UART TX among NUM_REQ byte sources.
// Optional UART_TX_SCHED_LOCK_EN keeps the grant on one requester until req_last.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [8*NUM_REQ-1:0]          req_data,
`ifdef UART_TX_SCHED_LOCK_EN
  input  logic [NUM_REQ-1:0]            req_last,
`endif
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          tx_busy,
  output logic                          tx_write_en,
  output logic [UART_DATA_BITS-1:0]     tx_data_in,
  output logic                          tx_en,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          sched_busy,
  output sched_state_t                  sched_state
);

  // Handshake: a byte moves only in a cycle where req_valid[i] & req_ready[i];
  // req_ready is combinational, one-hot, and only asserted in ARB.

  localparam int GW = $clog2(NUM_REQ);

  sched_state_t              state_q, state_d;
  logic [GW-1:0]             last_q, last_d;
  logic [GW-1:0]             gid_q, gid_d;
  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic                      found;
  logic [GW-1:0]             pick;
  int                        idx;
  logic                      baud_clear, baud_run;
`ifdef UART_TX_SCHED_LOCK_EN
  logic                      lock_q, lock_d;
`endif

  // First valid requester scanning upward from last_q+1, wrapping at NUM_REQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(last_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx[GW-1:0]]) begin
        found = 1'b1;
        pick  = idx[GW-1:0];
      end
    end
`ifdef UART_TX_SCHED_LOCK_EN
    if (lock_q) begin
      found = req_valid[last_q];
      pick  = last_q;
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gid_d       = gid_q;
    data_d      = data_q;
    req_ready   = '0;
    tx_write_en = 1'b0;
    baud_clear  = 1'b0;
    baud_run    = 1'b0;
`ifdef UART_TX_SCHED_LOCK_EN
    lock_d      = lock_q;
`endif
    unique case (state_q)
      ARB: begin
        baud_clear = 1'b1;
        if (found) begin
          req_ready[pick] = 1'b1;
          data_d          = req_data[{pick, 3'b000} +: 8];
          last_d          = pick;
          gid_d           = pick;
`ifdef UART_TX_SCHED_LOCK_EN
          lock_d          = ~req_last[pick];
`endif
          state_d         = LOAD;
        end
      end
      LOAD: begin
        tx_write_en = 1'b1;
        baud_clear  = 1'b1;
        state_d     = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        baud_run = 1'b1;
        if (tx_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        // Park the counter as the frame ends so ARB always sees it at zero.
        if (tx_busy) begin
          baud_run = 1'b1;
        end else begin
          baud_clear = 1'b1;
          state_d    = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB;
      last_q  <= GW'(NUM_REQ - 1);
      gid_q   <= '0;
      data_q  <= '0;
`ifdef UART_TX_SCHED_LOCK_EN
      lock_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      data_q  <= data_d;
`ifdef UART_TX_SCHED_LOCK_EN
      lock_q  <= lock_d;
`endif
    end
  end

  baud_tick_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (baud_clear),
    .run   (baud_run),
    .tick  (tx_en)
  );

  assign tx_data_in  = data_q;
  assign grant_id    = gid_q;
  assign sched_busy  = (state_q != ARB);
  assign sched_state = state_q;

endmodule
